// File: rtl/lif_neuron_bank_if.sv
// Spike event streams of the neuron bank: incoming weighted events and
// outgoing spike ids, each a valid/ready handshake.
interface lif_neuron_bank_if #(
    parameter int NEURON_ID_WIDTH = 8,
    parameter int WEIGHT_WIDTH    = 8
);
    logic                       s_axis_spike_valid;
    logic                       s_axis_spike_ready;
    logic [NEURON_ID_WIDTH-1:0] s_axis_spike_dest_id;
    logic [WEIGHT_WIDTH-1:0]    s_axis_spike_weight;
    logic                       m_axis_spike_valid;
    logic                       m_axis_spike_ready;
    logic [NEURON_ID_WIDTH-1:0] m_axis_spike_neuron_id;

    // Event source and spike consumer side.
    modport master (
        output s_axis_spike_valid,
        input  s_axis_spike_ready,
        output s_axis_spike_dest_id,
        output s_axis_spike_weight,
        input  m_axis_spike_valid,
        output m_axis_spike_ready,
        input  m_axis_spike_neuron_id
    );

    // Neuron bank side.
    modport slave (
        input  s_axis_spike_valid,
        output s_axis_spike_ready,
        input  s_axis_spike_dest_id,
        input  s_axis_spike_weight,
        output m_axis_spike_valid,
        input  m_axis_spike_ready,
        output m_axis_spike_neuron_id
    );
endinterface

// File: rtl/lif_neuron_bank.sv
// Time-multiplexed bank of signed leaky integrate-and-fire neurons.
// Events are integrated by a 2-cycle read-modify-write; a timestep tick
// sweeps every neuron once for leak and refractory countdown. Fired neuron
// ids leave through a first-word-fall-through FIFO with backpressure.
module lif_neuron_bank #(
    parameter int NUM_NEURONS      = 256,
    parameter int DATA_WIDTH       = 16,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int REFRAC_WIDTH     = 8,
    parameter int LEAK_SHIFT_WIDTH = 4,
    parameter int OUT_FIFO_DEPTH   = 16,
    parameter int THRESH_DEFAULT   = 1000,
    parameter int NEURON_ID_WIDTH  = $clog2(NUM_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         timestep_tick,
    lif_neuron_bank_if.slave             spike_bus,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_sel,
    input  logic [NEURON_ID_WIDTH-1:0]   cfg_addr,
    input  logic [31:0]                  cfg_data,
    input  logic [LEAK_SHIFT_WIDTH-1:0]  global_leak_shift,
    input  logic [REFRAC_WIDTH-1:0]      global_refrac_period,
    input  logic [DATA_WIDTH-1:0]        global_v_reset,
    output logic [31:0]                  spike_count,
    output logic                         array_busy,
    output logic                         timestep_done,
    output logic                         tick_overrun
);
    localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic signed [DATA_WIDTH-1:0] V_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] V_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, INTEG, INTEG_WB, LEAK_RD, LEAK_WR} state_t;

    state_t state, state_next;

    // Neuron state
    logic signed [DATA_WIDTH-1:0]   v_mem      [NUM_NEURONS];
    logic        [REFRAC_WIDTH-1:0] refrac_mem [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0]   thresh_mem [NUM_NEURONS];

    // Read stage of the read-modify-write
    logic        [NEURON_ID_WIDTH-1:0] work_id;
    logic signed [WEIGHT_WIDTH-1:0]    cap_weight;
    logic signed [DATA_WIDTH-1:0]      rd_v;
    logic        [REFRAC_WIDTH-1:0]    rd_refrac;
    logic signed [DATA_WIDTH-1:0]      rd_thresh;

    // Output FIFO
    logic [NEURON_ID_WIDTH-1:0] fifo_mem [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           fifo_count;

    logic tick_pending;
    logic s_ready, accept, sweep_start, integ_wb, leak_wr, sweep_last;
    logic fifo_has_room, push, pop, fire, cfg_hit;
    logic signed [DATA_WIDTH:0]   sum_wide;
    logic signed [DATA_WIDTH-1:0] v_sat, leak_v;
    logic cfg_unused;

    assign fifo_has_room = fifo_count < CNT_W'(OUT_FIFO_DEPTH);
    assign spike_bus.m_axis_spike_valid     = (fifo_count != '0);
    assign spike_bus.m_axis_spike_neuron_id = fifo_mem[rd_ptr];
    assign spike_bus.s_axis_spike_ready     = s_ready;
    assign pop        = spike_bus.m_axis_spike_valid && spike_bus.m_axis_spike_ready;
    assign array_busy = (state != IDLE);
    assign cfg_hit    = int'(cfg_addr) < NUM_NEURONS;
    assign cfg_unused = &{1'b0, cfg_data[31:DATA_WIDTH]};

    // Integration: sign-extend both operands one bit wider, then clamp on overflow.
    assign sum_wide = {rd_v[DATA_WIDTH-1], rd_v}
                    + {{(DATA_WIDTH+1-WEIGHT_WIDTH){cap_weight[WEIGHT_WIDTH-1]}}, cap_weight};
    assign v_sat = (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1])
                 ? (sum_wide[DATA_WIDTH] ? V_MIN : V_MAX)
                 : sum_wide[DATA_WIDTH-1:0];
    assign fire  = integ_wb && (rd_refrac == '0) && (v_sat >= rd_thresh);
    assign push  = fire;

    // Leak decays toward zero; shift 0 clears, and -1 decays to 0.
    assign leak_v = rd_v - (rd_v >>> global_leak_shift);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next  = state;
        s_ready     = 1'b0;
        accept      = 1'b0;
        sweep_start = 1'b0;
        integ_wb    = 1'b0;
        leak_wr     = 1'b0;
        sweep_last  = 1'b0;
        case (state)
            IDLE: begin
                s_ready = enable && !tick_pending && fifo_has_room;
                if (enable && tick_pending) begin
                    sweep_start = 1'b1;
                    state_next  = LEAK_RD;
                end else if (s_ready && spike_bus.s_axis_spike_valid) begin
                    accept     = 1'b1;
                    state_next = INTEG;
                end
            end
            INTEG:    state_next = INTEG_WB;
            INTEG_WB: begin
                integ_wb   = 1'b1;
                state_next = IDLE;
            end
            LEAK_RD:  state_next = LEAK_WR;
            LEAK_WR: begin
                leak_wr = 1'b1;
                if (work_id == NEURON_ID_WIDTH'(NUM_NEURONS - 1)) begin
                    sweep_last = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = LEAK_RD;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    // Tick latch; extra ticks while one is pending coalesce and flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_pending  <= 1'b0;
            tick_overrun  <= 1'b0;
            timestep_done <= 1'b0;
        end else begin
            if (timestep_tick)                    tick_pending <= 1'b1;
            else if (sweep_start)                 tick_pending <= 1'b0;
            if (timestep_tick && tick_pending)    tick_overrun <= 1'b1;
            timestep_done <= sweep_last;
        end
    end

    // Working neuron index: captured event target, or the sweep cursor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_id    <= '0;
            cap_weight <= '0;
        end else if (accept) begin
            work_id    <= spike_bus.s_axis_spike_dest_id;
            cap_weight <= spike_bus.s_axis_spike_weight;
        end else if (sweep_start) begin
            work_id    <= '0;
        end else if (leak_wr) begin
            work_id    <= work_id + NEURON_ID_WIDTH'(1);
        end
    end

    // Read stage: register the addressed neuron's fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v      <= '0;
            rd_refrac <= '0;
            rd_thresh <= '0;
        end else if (state == INTEG || state == LEAK_RD) begin
            rd_v      <= v_mem[work_id];
            rd_refrac <= refrac_mem[work_id];
            rd_thresh <= thresh_mem[work_id];
        end
    end

    // Neuron write-back; a config write issued later in this block wins a same-field collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: neuron state must come out of reset defined, so these arrays are flops with reset, not RAM.
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_mem[i]      <= '0;
                refrac_mem[i] <= '0;
                thresh_mem[i] <= DATA_WIDTH'(THRESH_DEFAULT);
            end
        end else begin
            if (integ_wb && rd_refrac == '0) begin
                if (fire) begin
                    v_mem[work_id]      <= global_v_reset;
                    refrac_mem[work_id] <= global_refrac_period;
                end else begin
                    v_mem[work_id]      <= v_sat;
                end
            end
            if (leak_wr) begin
                if (rd_refrac != '0) refrac_mem[work_id] <= rd_refrac - REFRAC_WIDTH'(1);
                else                 v_mem[work_id]      <= leak_v;
            end
            if (cfg_we && cfg_hit) begin
                case (cfg_sel)
                    2'd0:    v_mem[cfg_addr]      <= cfg_data[DATA_WIDTH-1:0];
                    2'd1:    refrac_mem[cfg_addr] <= cfg_data[REFRAC_WIDTH-1:0];
                    2'd2:    thresh_mem[cfg_addr] <= cfg_data[DATA_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Output FIFO; room was reserved when the event was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= work_id;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Total fired spikes, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    spike_count <= '0;
        else if (push) spike_count <= spike_count + 32'd1;
    end
endmodule

// File: tb/tb_lif_neuron_bank.sv
// Self-checking bench for lif_neuron_bank: scenario tasks with inline
// comparisons, and an output scoreboard of expected fired neuron ids.
module tb_lif_neuron_bank;
    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        timestep_tick;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [3:0]  global_leak_shift;
    logic [7:0]  global_refrac_period;
    logic [15:0] global_v_reset;
    logic [31:0] spike_count;
    logic        array_busy;
    logic        timestep_done;
    logic        tick_overrun;

    always #5 clk = ~clk;

    lif_neuron_bank_if #(.NEURON_ID_WIDTH(8), .WEIGHT_WIDTH(8)) bus ();

    lif_neuron_bank #(
        .NUM_NEURONS(N), .DATA_WIDTH(16), .WEIGHT_WIDTH(8), .REFRAC_WIDTH(8),
        .LEAK_SHIFT_WIDTH(4), .OUT_FIFO_DEPTH(16), .THRESH_DEFAULT(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .timestep_tick(timestep_tick),
        .spike_bus(bus),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .global_leak_shift(global_leak_shift), .global_refrac_period(global_refrac_period),
        .global_v_reset(global_v_reset),
        .spike_count(spike_count), .array_busy(array_busy),
        .timestep_done(timestep_done), .tick_overrun(tick_overrun)
    );

    int passed = 0;
    int total  = 0;
    int exp_q[$];
    int exp_spikes = 0;

    // Scoreboard: every popped output id must match the oldest expected spike.
    always @(negedge clk) begin
        int exp_id;
        if (rst_n && bus.m_axis_spike_valid && bus.m_axis_spike_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected: got id %0d, expected no spike", bus.m_axis_spike_neuron_id);
            end else begin
                exp_id = exp_q.pop_front();
                if (bus.m_axis_spike_neuron_id !== 8'(exp_id))
                    $display("FAIL out_id: got %0d expected %0d", bus.m_axis_spike_neuron_id, exp_id);
                else passed++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input int sel, input int addr, input int data);
        cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_addr = 8'(addr); cfg_data = 32'(data);
        step();
        cfg_we = 1'b0;
    endtask

    // Returns #1 after the handshake edge.
    task automatic send_event(input int id, input int w);
        bit ok = 1'b0;
        bus.s_axis_spike_valid   = 1'b1;
        bus.s_axis_spike_dest_id = 8'(id);
        bus.s_axis_spike_weight  = 8'(w);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.s_axis_spike_ready) begin ok = 1'b1; break; end
        end
        step();
        bus.s_axis_spike_valid = 1'b0;
        if (!ok) begin
            total++;
            $display("FAIL send_timeout: ready stayed 0, expected 1 for neuron %0d", id);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!array_busy) begin ok = 1'b1; break; end
        end
        step();
        if (!ok) begin
            total++;
            $display("FAIL idle_timeout: busy stayed 1, expected 0");
        end
    endtask

    task automatic test_reset();
        total++; if (bus.m_axis_spike_valid !== 1'b0) $display("FAIL rst_mvalid: got %b expected 0", bus.m_axis_spike_valid); else passed++;
        total++; if (bus.m_axis_spike_neuron_id !== 8'd0) $display("FAIL rst_mid: got %0d expected 0", bus.m_axis_spike_neuron_id); else passed++;
        total++; if (spike_count !== 32'd0) $display("FAIL rst_count: got %0d expected 0", spike_count); else passed++;
        total++; if ({array_busy, timestep_done, tick_overrun} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {array_busy, timestep_done, tick_overrun}); else passed++;
        total++; if (bus.s_axis_spike_ready !== 1'b1) $display("FAIL rst_sready: got %b expected 1", bus.s_axis_spike_ready); else passed++;
        total++; if (int'(dut.thresh_mem[5]) !== 1000) $display("FAIL rst_thresh: got %0d expected 1000", int'(dut.thresh_mem[5])); else passed++;
    endtask

    task automatic test_integrate();
        bus.m_axis_spike_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            send_event(5, 100);
            wait_idle();
        end
        total++; if (int'(dut.v_mem[5]) !== 900) $display("FAIL integ_v9: got %0d expected 900", int'(dut.v_mem[5])); else passed++;
        total++; if (bus.m_axis_spike_valid !== 1'b0 || spike_count !== 32'd0) $display("FAIL integ_nofire: got valid %b count %0d expected 0 0", bus.m_axis_spike_valid, spike_count); else passed++;
        send_event(5, 100);
        exp_q.push_back(5); exp_spikes++;
        step();
        total++; if (bus.m_axis_spike_valid !== 1'b0) $display("FAIL integ_lat1: got valid %b expected 0", bus.m_axis_spike_valid); else passed++;
        step();
        total++; if (bus.m_axis_spike_valid !== 1'b1 || bus.m_axis_spike_neuron_id !== 8'd5) $display("FAIL integ_lat2: got valid %b id %0d expected 1 5", bus.m_axis_spike_valid, bus.m_axis_spike_neuron_id); else passed++;
        total++; if (int'(dut.v_mem[5]) !== 0 || dut.refrac_mem[5] !== 8'd3) $display("FAIL integ_post: got v %0d refrac %0d expected 0 3", int'(dut.v_mem[5]), dut.refrac_mem[5]); else passed++;
        total++; if (spike_count !== 32'(exp_spikes)) $display("FAIL integ_count: got %0d expected %0d", spike_count, exp_spikes); else passed++;
        bus.m_axis_spike_ready = 1'b1;
        step(); step();
        // Refractory neuron discards the event.
        send_event(5, 100);
        wait_idle();
        total++; if (int'(dut.v_mem[5]) !== 0) $display("FAIL integ_refrac: got v %0d expected 0", int'(dut.v_mem[5])); else passed++;
    endtask

    task automatic test_saturation();
        cfg_write(0, 7, 32000);
        send_event(7, 127);
        exp_q.push_back(7); exp_spikes++;
        wait_idle();
        total++; if (int'(dut.v_mem[7]) !== 0) $display("FAIL sat_fire7: got v %0d expected 0", int'(dut.v_mem[7])); else passed++;
        // 32700+127 clamps to 32767, equal to the threshold, and the compare is inclusive.
        cfg_write(2, 8, 32767);
        cfg_write(0, 8, 32700);
        send_event(8, 127);
        exp_q.push_back(8); exp_spikes++;
        wait_idle();
        total++; if (int'(dut.v_mem[8]) !== 0 || dut.refrac_mem[8] !== 8'd3) $display("FAIL sat_pos: got v %0d refrac %0d expected 0 3", int'(dut.v_mem[8]), dut.refrac_mem[8]); else passed++;
        cfg_write(0, 9, -32700);
        send_event(9, -128);
        wait_idle();
        total++; if (int'(dut.v_mem[9]) !== -32768) $display("FAIL sat_neg: got v %0d expected -32768", int'(dut.v_mem[9])); else passed++;
        total++; if (spike_count !== 32'(exp_spikes)) $display("FAIL sat_count: got %0d expected %0d", spike_count, exp_spikes); else passed++;
    endtask

    task automatic test_leak();
        int n_done = -1;
        cfg_write(0, 10, 100);
        cfg_write(0, 11, -100);
        cfg_write(0, 12, -1);
        cfg_write(0, 13, 50);
        cfg_write(1, 13, 3);
        timestep_tick = 1'b1;
        step();
        timestep_tick = 1'b0;
        for (int n = 1; n <= 600; n++) begin
            step();
            if (n == 5) begin
                total++; if (array_busy !== 1'b1 || bus.s_axis_spike_ready !== 1'b0) $display("FAIL leak_busy: got busy %b ready %b expected 1 0", array_busy, bus.s_axis_spike_ready); else passed++;
            end
            if (timestep_done) begin n_done = n; break; end
        end
        total++; if (n_done !== 2 * N + 1) $display("FAIL leak_done_lat: got %0d cycles expected %0d", n_done, 2 * N + 1); else passed++;
        step();
        total++; if (timestep_done !== 1'b0) $display("FAIL leak_done_pulse: got %b expected 0", timestep_done); else passed++;
        total++; if (int'(dut.v_mem[10]) !== 75) $display("FAIL leak_pos: got %0d expected 75", int'(dut.v_mem[10])); else passed++;
        total++; if (int'(dut.v_mem[11]) !== -75) $display("FAIL leak_neg: got %0d expected -75", int'(dut.v_mem[11])); else passed++;
        total++; if (int'(dut.v_mem[12]) !== 0) $display("FAIL leak_m1: got %0d expected 0", int'(dut.v_mem[12])); else passed++;
        total++; if (int'(dut.v_mem[13]) !== 50 || dut.refrac_mem[13] !== 8'd2) $display("FAIL leak_refrac: got v %0d refrac %0d expected 50 2", int'(dut.v_mem[13]), dut.refrac_mem[13]); else passed++;
    endtask

    task automatic test_backpressure();
        bit saw_ready = 1'b0;
        bit drained   = 1'b0;
        bus.m_axis_spike_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cfg_write(2, 20 + i, 50);
            send_event(20 + i, 100);
            exp_q.push_back(20 + i); exp_spikes++;
            wait_idle();
        end
        total++; if (bus.s_axis_spike_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", bus.s_axis_spike_ready); else passed++;
        total++; if (bus.m_axis_spike_valid !== 1'b1 || bus.m_axis_spike_neuron_id !== 8'd20) $display("FAIL bp_head: got valid %b id %0d expected 1 20", bus.m_axis_spike_valid, bus.m_axis_spike_neuron_id); else passed++;
        bus.s_axis_spike_valid = 1'b1; bus.s_axis_spike_dest_id = 8'd60; bus.s_axis_spike_weight = 8'd1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.s_axis_spike_ready) saw_ready = 1'b1;
        end
        step();
        bus.s_axis_spike_valid = 1'b0;
        total++; if (saw_ready !== 1'b0) $display("FAIL bp_hold: got ready 1 while full, expected 0"); else passed++;
        bus.m_axis_spike_ready = 1'b1;
        step();
        total++; if (bus.s_axis_spike_ready !== 1'b1) $display("FAIL bp_first_pop: got ready %b expected 1", bus.s_axis_spike_ready); else passed++;
        for (int n = 0; n < 100; n++) begin
            step();
            if (exp_q.size() == 0) begin drained = 1'b1; break; end
        end
        total++; if (drained !== 1'b1) $display("FAIL bp_drain: got %0d ids left expected 0", exp_q.size()); else passed++;
        total++; if (spike_count !== 32'(exp_spikes)) $display("FAIL bp_count: got %0d expected %0d", spike_count, exp_spikes); else passed++;
    endtask

    task automatic test_tick_overrun();
        int  dones = 0;
        int  dones_at_accept = -1;
        bit  accepted = 1'b0;
        for (int c = 0; c < 1300; c++) begin
            timestep_tick = (c == 0 || c == 10 || c == 20);
            if (c == 5) begin
                bus.s_axis_spike_valid = 1'b1; bus.s_axis_spike_dest_id = 8'd40; bus.s_axis_spike_weight = 8'd10;
            end
            @(negedge clk);
            if (timestep_done) dones++;
            if (c == 15) begin
                total++; if (bus.s_axis_spike_ready !== 1'b0) $display("FAIL ovr_wait_ready: got %b expected 0", bus.s_axis_spike_ready); else passed++;
            end
            if (bus.s_axis_spike_valid && bus.s_axis_spike_ready) begin
                accepted = 1'b1; dones_at_accept = dones;
            end
            step();
            if (accepted) bus.s_axis_spike_valid = 1'b0;
        end
        timestep_tick = 1'b0;
        total++; if (tick_overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", tick_overrun); else passed++;
        total++; if (dones !== 2) $display("FAIL ovr_sweeps: got %0d sweeps expected 2", dones); else passed++;
        total++; if (dones_at_accept !== 2) $display("FAIL ovr_accept: got accept after %0d sweeps expected 2", dones_at_accept); else passed++;
        wait_idle();
        total++; if (int'(dut.v_mem[40]) !== 10) $display("FAIL ovr_event: got v %0d expected 10", int'(dut.v_mem[40])); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.m_axis_spike_ready = 1'b0;
        cfg_write(2, 50, 50);
        cfg_write(2, 51, 50);
        send_event(50, 100);
        exp_q.push_back(50); exp_spikes++;
        wait_idle();
        send_event(51, 100);
        step();
        total++; if (array_busy !== 1'b1 || bus.m_axis_spike_valid !== 1'b1) $display("FAIL rmid_pre: got busy %b valid %b expected 1 1", array_busy, bus.m_axis_spike_valid); else passed++;
        rst_n = 1'b0;
        #1;
        exp_q.delete(); exp_spikes = 0;
        total++; if (bus.m_axis_spike_valid !== 1'b0 || bus.m_axis_spike_neuron_id !== 8'd0) $display("FAIL rmid_fifo: got valid %b id %0d expected 0 0", bus.m_axis_spike_valid, bus.m_axis_spike_neuron_id); else passed++;
        total++; if (spike_count !== 32'd0) $display("FAIL rmid_count: got %0d expected 0", spike_count); else passed++;
        total++; if ({array_busy, timestep_done, tick_overrun} !== 3'b000) $display("FAIL rmid_flags: got %b expected 000", {array_busy, timestep_done, tick_overrun}); else passed++;
        total++; if (int'(dut.thresh_mem[50]) !== 1000 || int'(dut.v_mem[40]) !== 0) $display("FAIL rmid_mem: got thresh %0d v %0d expected 1000 0", int'(dut.thresh_mem[50]), int'(dut.v_mem[40])); else passed++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        enable = 1'b1; timestep_tick = 1'b0;
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_addr = 8'd0; cfg_data = 32'd0;
        global_leak_shift = 4'd2; global_refrac_period = 8'd3; global_v_reset = 16'd0;
        bus.s_axis_spike_valid = 1'b0; bus.s_axis_spike_dest_id = 8'd0; bus.s_axis_spike_weight = 8'd0;
        bus.m_axis_spike_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        test_reset();
        test_integrate();
        test_saturation();
        test_leak();
        test_backpressure();
        test_tick_overrun();
        test_reset_mid();
        total++; if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d ids unseen expected 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
